// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : controller_pkg
// Purpose  : Shared types and constants for the tc reset sequencer: FSM state
//            encoding, Avalon-MM register word addresses and STATUS bit
//            positions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_STATUS    = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_STAGGER   = 3'd2;
    localparam logic [2:0] ADDR_HOLD      = 3'd3;
    localparam logic [2:0] ADDR_START     = 3'd4;
    localparam logic [2:0] ADDR_ABORT     = 3'd5;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_ACTIVE_LSB  = 4;
    localparam int STAT_PENDING_LSB = 8;

endpackage
`default_nettype wire

// File: rtl/controller_lowbit_clr.sv
`default_nettype none
// ============================================================================
// Module   : controller_lowbit_clr
// Purpose  : Clears the lowest set bit of a mask (combinational).
// Ports    : i_mask  in  NCH  input mask
//            o_mask  out NCH  i_mask with its lowest set bit cleared
// Revision : 1.0 - initial release
// ============================================================================
module controller_lowbit_clr #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] i_mask,
    output logic [NCH-1:0] o_mask
);

    // m & (m - 1) removes exactly the least significant one; zero stays zero.
    assign o_mask = i_mask & (i_mask - NCH'(1));

endmodule
`default_nettype wire

// File: rtl/controller_tc_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : controller_tc_reset_seq
// Purpose  : Avalon-MM slave sequencing the tc subsystem reset lines. Requested
//            channels are asserted together for PULSE_LEN cycles, then
//            released lowest index first, STAGGER cycles apart. A hold mask
//            forces lines high independently of the sequencer.
// Ports    : clk         in  1   system clock
//            reset       in  1   asynchronous active-high reset
//            address     in  3   register word address
//            chipselect  in  1   slave select
//            write_n     in  1   active-low write strobe
//            writedata   in  32  write data
//            readdata    out 32  read data, combinational
//            out_port    out NCH reset lines to tc channels, active-high
//            busy        out 1   sequence in progress
// Revision : 1.0 - initial release
// ============================================================================
module controller_tc_reset_seq
    import controller_pkg::*;
#(
    parameter int NCH             = 4,
    parameter int CNT_W           = 16,
    parameter int PULSE_DEFAULT   = 16,
    parameter int STAGGER_DEFAULT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     address,
    input  logic           chipselect,
    input  logic           write_n,
    input  logic [31:0]    writedata,
    output logic [31:0]    readdata,
    output logic [NCH-1:0] out_port,
    output logic           busy
);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_pulse_len, r_stagger;
    logic [NCH-1:0]   r_active, w_active_nxt;
    logic [NCH-1:0]   r_pending, w_pending_nxt;
    logic [NCH-1:0]   r_hold, r_out;
    logic             r_done, w_done_nxt;

    logic             w_wr, w_abort, w_done_clr;
    logic [NCH-1:0]   w_start_bits, w_active_lowclr, w_release_mask;
    logic [CNT_W-1:0] w_pulse_m1;
    logic [31:0]      w_status;
    logic             w_unused_wdata;

    assign w_wr         = chipselect & ~write_n;
    assign w_abort      = w_wr && (address == ADDR_ABORT);
    assign w_done_clr   = w_wr && (address == ADDR_STATUS) && writedata[STAT_DONE_BIT];
    assign w_start_bits = (w_wr && (address == ADDR_START)) ? writedata[NCH-1:0] : '0;
    assign w_unused_wdata = ^writedata[31:CNT_W];

    // A programmed pulse length of 0 is treated as 1.
    assign w_pulse_m1 = (r_pulse_len == '0) ? '0 : r_pulse_len - CNT_W'(1);

    controller_lowbit_clr #(.NCH(NCH)) u_lowbit_clr (
        .i_mask (r_active),
        .o_mask (w_active_lowclr)
    );

    // STAGGER of 0 drops every remaining line in one release step.
    assign w_release_mask = (r_stagger == '0) ? '0 : w_active_lowclr;

    // The RELEASE state is the cycle whose closing edge clears lines, so the
    // counters hand over to RELEASE one cycle before they would hit zero;
    // this keeps the pulse at PULSE_LEN cycles and the spacing at STAGGER.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending | w_start_bits;
        w_done_nxt    = r_done & ~w_done_clr;
        if (w_abort) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_active_nxt  = '0;
            w_pending_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pending != '0) begin
                        w_active_nxt  = r_pending;
                        w_pending_nxt = w_start_bits;
                        w_cnt_nxt     = w_pulse_m1;
                        w_state_nxt   = (w_pulse_m1 == '0) ? ST_RELEASE : ST_ASSERT;
                    end
                end
                ST_ASSERT, ST_GAP: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    w_active_nxt = w_release_mask;
                    if (w_release_mask == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (r_stagger <= CNT_W'(1)) begin
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_cnt_nxt   = r_stagger - CNT_W'(1);
                        w_state_nxt = ST_GAP;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_active    <= '0;
            r_pending   <= '0;
            r_done      <= 1'b0;
            r_hold      <= '0;
            r_out       <= '0;
            r_pulse_len <= CNT_W'(PULSE_DEFAULT);
            r_stagger   <= CNT_W'(STAGGER_DEFAULT);
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
            r_done    <= w_done_nxt;
            r_out     <= r_active | r_hold;
            if (w_wr && (address == ADDR_PULSE_LEN)) r_pulse_len <= writedata[CNT_W-1:0];
            if (w_wr && (address == ADDR_STAGGER))   r_stagger   <= writedata[CNT_W-1:0];
            if (w_wr && (address == ADDR_HOLD))      r_hold      <= writedata[NCH-1:0];
        end
    end

    always_comb begin
        w_status                                 = '0;
        w_status[STAT_BUSY_BIT]                  = busy;
        w_status[STAT_DONE_BIT]                  = r_done;
        w_status[STAT_ACTIVE_LSB +: NCH]         = r_active;
        w_status[STAT_PENDING_LSB +: NCH]        = r_pending;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_STATUS:    readdata             = w_status;
            ADDR_PULSE_LEN: readdata[CNT_W-1:0]  = r_pulse_len;
            ADDR_STAGGER:   readdata[CNT_W-1:0]  = r_stagger;
            ADDR_HOLD:      readdata[NCH-1:0]    = r_hold;
            default:        readdata             = '0;
        endcase
    end

    assign out_port = r_out;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_controller_tc_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_controller_tc_reset_seq
// Purpose  : Self-checking bench for controller_tc_reset_seq. A timestamp
//            based reference model predicts out_port, busy and read data each
//            cycle; expectations are queued and checked by a monitor.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_controller_tc_reset_seq;

    localparam int NCH   = 4;
    localparam int CNT_W = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [2:0]     address = '0;
    logic           chipselect = 1'b0;
    logic           write_n = 1'b1;
    logic [31:0]    writedata = '0;
    logic [31:0]    readdata;
    logic [NCH-1:0] out_port;
    logic           busy;

    always #5 clk = ~clk;

    controller_tc_reset_seq #(
        .NCH(NCH), .CNT_W(CNT_W), .PULSE_DEFAULT(16), .STAGGER_DEFAULT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy)
    );

    typedef struct {
        bit          chk_rd;
        logic [2:0]  addr;
        logic [31:0] rd;
        logic [3:0]  out;
        logic        busy;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: channels released at absolute cycle timestamps.
    logic [15:0] m_pulse, m_stag;
    logic [3:0]  m_hold, m_pending, m_active, m_out;
    logic        m_done, m_busy;
    int          m_next_rel;
    int          cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] drop_lowest(input logic [3:0] m);
        logic [3:0] r;
        r = m;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) begin
                r[i] = 1'b0;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {20'b0, m_pending, m_active, 2'b00, m_done, m_busy};
            3'd1:    return {16'b0, m_pulse};
            3'd2:    return {16'b0, m_stag};
            3'd3:    return {28'b0, m_hold};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_pulse = 16'd16; m_stag = 16'd4; m_hold = '0; m_pending = '0;
        m_active = '0; m_out = '0; m_done = 1'b0; m_busy = 1'b0;
        m_next_rel = 0; cyc = 0;
    endtask

    task automatic model_step(input bit wr, input logic [2:0] a, input logic [31:0] d);
        logic [3:0] nact, npend, start;
        logic       ndone, nbusy;
        nact  = m_active;
        npend = m_pending;
        nbusy = m_busy;
        start = (wr && a == 3'd4) ? d[3:0] : 4'h0;
        ndone = (wr && a == 3'd0 && d[1]) ? 1'b0 : m_done;
        if (wr && a == 3'd5) begin
            nact = '0; npend = '0; nbusy = 1'b0;
        end else begin
            if (!m_busy) begin
                if (m_pending != 0) begin
                    nact = m_pending; npend = '0; nbusy = 1'b1;
                    m_next_rel = cyc + ((m_pulse == 0) ? 1 : int'(m_pulse));
                end
            end else if (cyc == m_next_rel) begin
                nact = (m_stag == 0) ? 4'h0 : drop_lowest(m_active);
                if (nact == 0) begin
                    nbusy = 1'b0; ndone = 1'b1;
                end else begin
                    m_next_rel = cyc + int'(m_stag);
                end
            end
            npend = npend | start;
        end
        m_out = m_active | m_hold;
        if (wr && a == 3'd1) m_pulse = d[15:0];
        if (wr && a == 3'd2) m_stag  = d[15:0];
        if (wr && a == 3'd3) m_hold  = d[3:0];
        m_active = nact; m_pending = npend; m_done = ndone; m_busy = nbusy;
        cyc++;
    endtask

    task automatic bus(input bit cs, input bit we, input logic [2:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        chipselect = cs; write_n = ~we; address = a; writedata = d;
        e.chk_rd = cs && !we;
        e.addr   = a;
        e.rd     = model_read(a);
        e.out    = m_out;
        e.busy   = m_busy;
        sbq.push_back(e);
        model_step(cs && we, a, d);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d); bus(1'b1, 1'b1, a, d); endtask
    task automatic rd(input logic [2:0] a); bus(1'b1, 1'b0, a, 32'h0); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 3'd0, 32'h0); endtask

    task automatic wait_idle(input int max_cyc);
        int k;
        k = 0;
        while ((m_busy || m_pending != 0) && k < max_cyc) begin
            idle(1);
            k++;
        end
        chk("seq_timeout", {31'b0, (m_busy || m_pending != 0)}, 32'h0);
    endtask

    // Monitor: compares everything queued for this cycle, away from posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("out_port", {28'b0, out_port}, {28'b0, e.out});
                chk("busy", {31'b0, busy}, {31'b0, e.busy});
                if (e.chk_rd) chk($sformatf("readdata[a=%0d]", e.addr), readdata, e.rd);
            end
        end
    end

    initial begin
        logic [31:0] d;
        int r;
        model_reset();
        #1 chk("out_port_in_reset", {28'b0, out_port}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Register defaults after reset.
        for (int a = 0; a < 8; a++) rd(3'(a));

        // Staggered release of 1011, then clear done.
        wr(3'd1, 32'd3); wr(3'd2, 32'd2); wr(3'd4, 32'hB);
        wait_idle(100); rd(3'd0);
        wr(3'd0, 32'h2); rd(3'd0);

        // Minimum pulse, all released together.
        wr(3'd2, 32'd0); wr(3'd1, 32'd0); wr(3'd4, 32'hF);
        wait_idle(100); idle(2); rd(3'd0);

        // START during ASSERT queues into pending.
        wr(3'd1, 32'd4); wr(3'd2, 32'd1); wr(3'd4, 32'h1);
        idle(2); wr(3'd4, 32'h6); rd(3'd0);
        wait_idle(100); rd(3'd0); wr(3'd0, 32'h2);

        // Hold plus ABORT during ASSERT.
        wr(3'd3, 32'h8); wr(3'd4, 32'h1); idle(2);
        wr(3'd5, 32'h0); idle(1); rd(3'd0); idle(2); rd(3'd3);
        wr(3'd3, 32'h0); idle(2);

        // Reset during GAP drops all lines immediately.
        wr(3'd1, 32'd2); wr(3'd2, 32'd3); wr(3'd3, 32'h4); wr(3'd4, 32'h3);
        idle(4);
        @(negedge clk);
        chipselect = 1'b0;
        #3 reset = 1'b1;
        #1 chk("out_port_async_rst", {28'b0, out_port}, 32'h0);
        chk("busy_async_rst", {31'b0, busy}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) rd(3'(a));

        // Randomised traffic.
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 99);
            d = $urandom();
            if (r < 40)      idle(1);
            else if (r < 60) rd(3'($urandom_range(0, 7)));
            else if (r < 70) wr(3'd4, d);
            else if (r < 75) wr(3'd1, {d[31:16], 16'($urandom_range(0, 5))});
            else if (r < 80) wr(3'd2, {d[31:16], 16'($urandom_range(0, 3))});
            else if (r < 84) wr(3'd3, d);
            else if (r < 88) wr(3'd0, d);
            else if (r < 90) wr(3'd5, d);
            else if (r < 93) wr(3'($urandom_range(6, 7)), d);
            else             rd(3'd0);
        end
        wait_idle(400);
        rd(3'd0);

        @(negedge clk);
        chipselect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controller_tc_reset_seq.md
Name: controller_tc_reset_seq

Overview:
- Avalon-MM slave that sequences the four tc subsystem reset lines.
- Software requests a reset of any subset of channels. The block asserts the requested lines together for a programmable pulse length, then releases them one at a time, lowest index first, with a programmable stagger.
- A software hold mask forces lines high independently of the sequencer.
- Sits on the controller system bus beside the other PIO-style peripherals; out_port drives the tc reset inputs.

Parameters:
- NCH, 4, number of reset channels.
- CNT_W, 16, width of the pulse and stagger counters and registers.
- PULSE_DEFAULT, 16, reset value of PULSE_LEN.
- STAGGER_DEFAULT, 4, reset value of STAGGER.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data; combinational, zero wait states
- out_port  out  NCH  reset lines to tc channels, active-high
- busy  out  1  sequence in progress

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state=IDLE; active, pending, hold and done all 0.
  - PULSE_LEN=PULSE_DEFAULT, STAGGER=STAGGER_DEFAULT.
  - out_port=0, busy=0.
- Write strobe: wr = chipselect & ~write_n.
- Register map:
  - 0 STATUS (R): bit0 busy, bit1 done, [7:4] active, [11:8] pending. Write with bit1=1 clears done.
  - 1 PULSE_LEN (RW, CNT_W bits): a written value of 0 behaves as 1.
  - 2 STAGGER (RW, CNT_W bits): 0 releases all active channels in the same cycle.
  - 3 HOLD (RW, NCH bits).
  - 4 START (W): pending |= writedata[NCH-1:0].
  - 5 ABORT (W, data ignored).
  - 6, 7: read 0, writes ignored.
- Output: out_port = active | hold, registered. busy = (state != IDLE).
- FSM states: IDLE, ASSERT, RELEASE, GAP.
  - IDLE: if pending != 0, go to ASSERT. active <= pending, pending <= 0, cnt <= max(PULSE_LEN,1)-1.
  - ASSERT: cnt decrements to 0, then go to RELEASE. Each active line is high for exactly max(PULSE_LEN,1) cycles before the first release.
  - RELEASE: clear the lowest set bit of active (all bits if STAGGER=0).
    - If active becomes 0: go to IDLE and set done.
    - Otherwise: go to GAP with cnt <= STAGGER-1.
  - GAP: cnt reaches 0, then go to RELEASE.
- Latency: START write at edge t → out_port high from edge t+2.
- Simultaneous events:
  - A START write in the same cycle IDLE samples pending: the new bits join pending. They are not lost; they are served next sequence if pending was already latched that edge.
  - A START during a sequence accumulates into pending. Its bits are served by a fresh sequence after return to IDLE, and done is still set at the end of the current sequence.
  - START for a channel already in active is not merged into the current sequence; it is queued in pending.
  - A PULSE_LEN/STAGGER write mid-sequence takes effect at the next counter load only.
- ABORT:
  - Next edge: active=0, pending=0, state=IDLE; done unchanged; hold unaffected.
  - ABORT and START in the same cycle: ABORT wins.
- Reset mid-sequence: all lines drop asynchronously to 0. Hold also clears.

Decomposition:
- Shared package controller_pkg:
  - state enum (IDLE/ASSERT/RELEASE/GAP);
  - register address constants ADDR_STATUS..ADDR_ABORT;
  - STATUS bit positions.
- One natural sub-module: controller_lowbit_clr, a combinational find-lowest-set-bit-and-clear on an NCH-bit mask.

Test Plan:
1. Reset, then read all registers → STATUS=0, PULSE_LEN=16, STAGGER=4, HOLD=0, out_port=0.
2. PULSE_LEN=3, STAGGER=2, START=4'b1011 → out_port=1011 for 3 cycles, then 1010, then 1000 two cycles later, then 0000 two cycles later. done=1, busy=0. Write STATUS bit1 → done=0.
3. STAGGER=0, PULSE_LEN=0, START=4'b1111 → out_port=1111 for exactly 1 cycle, then 0000.
4. START=0001; during ASSERT, START=0110 → pending=0110 visible in STATUS. After the first sequence ends, a second sequence drives 0110.
5. HOLD=1000 with START=0001 running → out_port=1001. ABORT during ASSERT → out_port=1000 next cycle; pending cleared; done stays 0.
6. Assert reset during GAP → out_port=0 immediately. After release, STATUS=0 and the registers are back at their defaults.
